scan_key_sequencer: RTL and testbench
=====================================

Name: scan_key_sequencer

Overview:
- Transmit side of the scan-unlock protocol: streams a KEY_NUMBER-word key onto the checker's scan_key input, one word per clock, then waits for scan_unlock.
- Sits between the secure key source (fuse/OTP shadow, presented on key_in) and the scan-control checker (vim_scan_control).
- Reports done/fail status to the test-access controller.

Parameters:
- KEY_WIDTH, 32, width of one key word and of scan_key.
- KEY_NUMBER, 8, number of words per unlock sequence.
- TIMEOUT_CYCLES, 16, maximum cycles spent in WAIT_UNLOCK before declaring fail (≥4).

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request an unlock sequence; sampled only in IDLE.
- key_in  input  KEY_WIDTH*KEY_NUMBER  full key; word k = key_in[k*KEY_WIDTH +: KEY_WIDTH].
- scan_unlock  input  1  unlock status from the checker.
- scan_key  output  KEY_WIDTH  registered key word to the checker.
- busy  output  1  high in SEND and WAIT_UNLOCK.
- done  output  1  level; unlock achieved.
- fail  output  1  level; timeout without unlock.

Behaviour:
- Reset values: scan_key = 0, busy = 0, done = 0, fail = 0. State = IDLE, word index = 0, timeout count = 0, latched key = 0.
- Reset asserted mid-sequence aborts immediately and returns all of the above to reset values.
- States: IDLE, SEND, WAIT_UNLOCK, DONE, FAIL.
- IDLE:
  - Each cycle, scan_key <= ~key_in word 0 (guard value, never matches word 0).
  - start=1 with scan_unlock=0 at edge T:
    - latch key_in;
    - scan_key <= word 0; index <= 1;
    - done/fail cleared; state -> SEND.
  - start=1 with scan_unlock=1: state -> DONE, done=1. No key word is ever driven.
- SEND:
  - At each edge, scan_key <= latched word[index]; index increments.
  - Word k is visible on scan_key during cycle T+k, for k = 0..KEY_NUMBER-1.
  - Each word is held exactly one cycle, back-to-back with no gaps. The checker advances on every matching sample, so repeated or stretched words are forbidden.
  - After word KEY_NUMBER-1: scan_key <= ~word 0 (guard), timeout count <= 0, state -> WAIT_UNLOCK.
  - The guard value is also driven in WAIT_UNLOCK, DONE and FAIL.
- WAIT_UNLOCK:
  - Each cycle, sample scan_unlock.
  - scan_unlock=1 -> DONE (done=1, busy=0).
  - Otherwise count++; when count reaches TIMEOUT_CYCLES-1 with no unlock -> FAIL (fail=1, busy=0).
  - If scan_unlock and the timeout expire on the same cycle, unlock wins.
  - With a matching checker, scan_unlock rises at edge T+KEY_NUMBER+1 and done rises at edge T+KEY_NUMBER+2.
- DONE / FAIL:
  - done/fail held as levels.
  - A start sampled in either state re-enters the IDLE start decision on that edge, with identical behaviour to IDLE.
- start while busy is ignored (no restart, no re-latch).
- key_in changes after the latching edge have no effect on the in-flight sequence.
- Index width: $clog2(KEY_NUMBER)+1 bits. No wrap beyond KEY_NUMBER; the index is reset on every start.

Optional Feature:
- Macro: SCAN_KEY_ZEROIZE_EN.
- Defined:
  - On entry to DONE or FAIL, the latched key register is cleared to 0 in the same edge.
  - On any reset, the latched key register is also cleared to 0.
  - scan_key is then driven to all-zeros instead of the ~word 0 guard.
  - In IDLE, scan_key is all-zeros; the guard value is not derived from key_in while idle.
- Undefined:
  - The latched key is retained until the next start.
  - The guard value is ~word 0 in all non-SEND states, as specified above.

Test Plan:
- Key 256'h87A5E932FA1BC49DFF8A0B2C3D4E5F607891ABCDEF0123456789ABCDEF012345, paired with vim_scan_control, pulse start -> scan_key shows EF012345, 6789ABCD, EF012345, 7891ABCD, 3D4E5F60, FF8A0B2C, FA1BC49D, 87A5E932 on consecutive cycles; then guard 10FEDCBA; scan_unlock=1; done=1 at T+10; busy falls with done.
- Same key but checker's scan_unlock tied 0 -> fail=1 exactly TIMEOUT_CYCLES cycles after entering WAIT_UNLOCK; done stays 0; scan_key = 10FEDCBA.
- scan_unlock=1 before start -> done=1 at the next edge; scan_key never equals any key word; busy never asserts.
- start re-pulsed at cycle T+3 and key_in changed at T+1 -> the sequence is unaffected; all 8 original words are sent once.
- rst_n asserted at cycle T+4 -> scan_key=0, busy=0, state IDLE. A new start after release sends the full sequence from word 0 and unlock is achieved.
- With SCAN_KEY_ZEROIZE_EN: after done, the internal key register reads 0 and scan_key=0. Without the macro, the register still holds the key.

Source files
------------

// File: rtl/scan_key_sequencer.sv
// Scan-unlock transmit sequencer: streams a latched key onto scan_key one word per clock, then waits for scan_unlock.
// Optional build macro SCAN_KEY_ZEROIZE_EN clears the latched key on DONE/FAIL and drives an all-zero guard word.
module scan_key_sequencer #(
    parameter int KEY_WIDTH      = 32,
    parameter int KEY_NUMBER     = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [KEY_WIDTH*KEY_NUMBER-1:0]  key_in,
    input  logic                             scan_unlock,
    output logic [KEY_WIDTH-1:0]             scan_key,
    output logic                             busy,
    output logic                             done,
    output logic                             fail
);

    localparam int IDX_W = $clog2(KEY_NUMBER) + 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(KEY_NUMBER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SEND = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_DONE = 3'd3;
    localparam logic [2:0] S_FAIL = 3'd4;

`ifdef SCAN_KEY_ZEROIZE_EN
    localparam bit ZEROIZE = 1'b1;
`else
    localparam bit ZEROIZE = 1'b0;
`endif

    logic [2:0]                        state;
    logic [IDX_W-1:0]                  idx;
    logic [CNT_W-1:0]                  cnt;
    logic [KEY_WIDTH*KEY_NUMBER-1:0]   key_lat;
    logic [KEY_WIDTH-1:0]              cur_word;
    logic [KEY_WIDTH-1:0]              idle_guard;
    logic [KEY_WIDTH-1:0]              lat_guard;
    logic [KEY_WIDTH-1:0]              hold_guard;

    // Guard words are the inverse of word 0 so the checker can never see a spurious first match.
    always_comb begin
        idle_guard = '0;
        lat_guard  = '0;
        if (!ZEROIZE) begin
            idle_guard = ~key_in[KEY_WIDTH-1:0];
            lat_guard  = ~key_lat[KEY_WIDTH-1:0];
        end
    end

    assign hold_guard = (state == S_IDLE) ? idle_guard : lat_guard;

    always_comb begin
        cur_word = '0;
        for (int k = 0; k < KEY_NUMBER; k++) begin
            if (idx == k[IDX_W-1:0])
                cur_word = key_lat[k*KEY_WIDTH +: KEY_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            idx      <= '0;
            cnt      <= '0;
            key_lat  <= '0;
            scan_key <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (start && scan_unlock) begin
                        // Already unlocked: finish without ever exposing a key word.
                        state    <= S_DONE;
                        scan_key <= hold_guard;
                        if (ZEROIZE) key_lat <= '0;
                    end else if (start) begin
                        key_lat  <= key_in;
                        scan_key <= key_in[KEY_WIDTH-1:0];
                        idx      <= IDX_W'(1);
                        state    <= S_SEND;
                    end else begin
                        scan_key <= hold_guard;
                    end
                end
                S_SEND: begin
                    if (idx == IDX_END) begin
                        scan_key <= lat_guard;
                        cnt      <= '0;
                        state    <= S_WAIT;
                    end else begin
                        scan_key <= cur_word;
                        idx      <= idx + IDX_W'(1);
                    end
                end
                S_WAIT: begin
                    scan_key <= lat_guard;
                    // Unlock takes priority over a timeout landing on the same edge.
                    if (scan_unlock) begin
                        state <= S_DONE;
                        if (ZEROIZE) key_lat <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= S_FAIL;
                        if (ZEROIZE) key_lat <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    scan_key <= '0;
                end
            endcase
        end
    end

    assign busy = (state == S_SEND) || (state == S_WAIT);
    assign done = (state == S_DONE);
    assign fail = (state == S_FAIL);

endmodule

// File: tb/tb_scan_key_sequencer.sv
// Directed bench for scan_key_sequencer: send order, unlock/timeout, early unlock, restart immunity, mid-sequence reset.
module tb_scan_key_sequencer;

    localparam logic [255:0] KEY =
        256'h87A5E932FA1BC49DFF8A0B2C3D4E5F607891ABCDEF0123456789ABCDEF012345;
    localparam logic [255:0] ALT_KEY = {8{32'h5A5A0F0F}};
`ifdef SCAN_KEY_ZEROIZE_EN
    localparam logic [31:0] GUARD  = 32'h0;
    localparam logic [31:0] IGUARD = 32'h0;
`else
    localparam logic [31:0] GUARD  = 32'h10FEDCBA;
    localparam logic [31:0] IGUARD = 32'h10FEDCBA;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [255:0] key_in;
    logic         scan_unlock;
    logic [31:0]  scan_key;
    logic         busy, done, fail;

    logic [31:0] words [8];
    int checks = 0;
    int errors = 0;

    scan_key_sequencer #(.KEY_WIDTH(32), .KEY_NUMBER(8), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in),
        .scan_unlock(scan_unlock), .scan_key(scan_key),
        .busy(busy), .done(done), .fail(fail)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic is_key_word(input logic [31:0] v);
        for (int k = 0; k < 8; k++)
            if (v == words[k]) return 1'b1;
        return 1'b0;
    endfunction

    // mode 1: change key_in after the first word and re-pulse start into edge T+3.
    task automatic send_seq(input int mode);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("word%0d", k), 256'(scan_key), 256'(words[k]));
            chk($sformatf("busy%0d", k), 256'(busy), 256'(1'b1));
            if (mode == 1 && k == 1) key_in = ALT_KEY;
            if (mode == 1 && k == 2) start = 1'b1;
            if (mode == 1 && k == 3) start = 1'b0;
            tick();
        end
        chk("guard", 256'(scan_key), 256'(GUARD));
        chk("guard_busy", 256'(busy), 256'(1'b1));
        chk("guard_done", 256'(done), 256'(1'b0));
    endtask

    initial begin
        for (int k = 0; k < 8; k++) begin
            logic [255:0] kk;
            kk = KEY;
            words[k] = kk[k*32 +: 32];
        end
        rst_n = 1'b0; start = 1'b0; scan_unlock = 1'b0; key_in = KEY;
        tick(); tick();
        chk("rst_scan_key", 256'(scan_key), 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_done", 256'(done), 256'(0));
        chk("rst_fail", 256'(fail), 256'(0));
        chk("rst_key_lat", dut.key_lat, 256'(0));
        rst_n = 1'b1;
        tick();
        chk("idle_guard", 256'(scan_key), 256'(IGUARD));

        // Checker already unlocked: straight to DONE, no key word exposed.
        scan_unlock = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("pre_done", 256'(done), 256'(1));
        chk("pre_fail", 256'(fail), 256'(0));
        for (int i = 0; i < 3; i++) begin
            chk("pre_busy", 256'(busy), 256'(0));
            chk("pre_noword", 256'(is_key_word(scan_key)), 256'(0));
            tick();
        end

        // Normal unlock: scan_unlock rises after edge T+9, done at T+10.
        scan_unlock = 1'b0;
        send_seq(0);
        tick();
        chk("t9_done", 256'(done), 256'(0));
        chk("t9_busy", 256'(busy), 256'(1));
        scan_unlock = 1'b1;
        tick();
        chk("t10_done", 256'(done), 256'(1));
        chk("t10_busy", 256'(busy), 256'(0));
        scan_unlock = 1'b0;
        tick();
`ifdef SCAN_KEY_ZEROIZE_EN
        chk("zeroized_lat", dut.key_lat, 256'(0));
        chk("zeroized_key", 256'(scan_key), 256'(0));
`else
        chk("retained_lat", dut.key_lat, KEY);
        chk("retained_guard", 256'(scan_key), 256'(GUARD));
`endif

        // Timeout: WAIT entered at T+8, fail exactly 16 cycles later.
        send_seq(0);
        for (int i = 0; i < 15; i++) tick();
        chk("to_early_fail", 256'(fail), 256'(0));
        chk("to_early_busy", 256'(busy), 256'(1));
        tick();
        chk("to_fail", 256'(fail), 256'(1));
        chk("to_done", 256'(done), 256'(0));
        chk("to_busy", 256'(busy), 256'(0));
        chk("to_guard", 256'(scan_key), 256'(GUARD));

        // Restart and key change while busy are ignored.
        send_seq(1);
        key_in = KEY;
        scan_unlock = 1'b1;
        tick();
        chk("rs_done", 256'(done), 256'(1));
        chk("rs_fail", 256'(fail), 256'(0));
        scan_unlock = 1'b0;

        // Reset in the middle of SEND aborts everything.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("pr_word%0d", k), 256'(scan_key), 256'(words[k]));
            if (k < 3) tick();
        end
        rst_n = 1'b0;
        #1;
        chk("mr_scan_key", 256'(scan_key), 256'(0));
        chk("mr_busy", 256'(busy), 256'(0));
        chk("mr_state", 256'(dut.state), 256'(0));
        chk("mr_done", 256'(done), 256'(0));
        tick();
        rst_n = 1'b1;
        tick();
        send_seq(0);
        scan_unlock = 1'b1;
        tick();
        chk("mr_unlock_done", 256'(done), 256'(1));
        scan_unlock = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
